// File: rtl/axil_mem_bridge.sv
// axil_mem_bridge: PicoRV32-style native memory port to AXI4-lite master bridge.
// One transaction in flight; every request runs to completion unless reset intervenes.
module axil_mem_bridge #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter logic [31:0] ERR_RDATA    = 32'hDEAD_BEEF,
    parameter int unsigned ERRCNT_WIDTH = 8,
    parameter int unsigned IFETCH_PROT  = 1
) (
    input  logic                    clk,
    input  logic                    rsi_resetn,
    // CPU native memory port
    input  logic                    mem_valid,
    input  logic                    mem_instr,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [31:0]             mem_wdata,
    input  logic [3:0]              mem_wstrb,
    output logic                    mem_ready,
    output logic [31:0]             mem_rdata,
    output logic                    bus_err,
    output logic [ERRCNT_WIDTH-1:0] err_count,
    // AXI4-lite write address
    output logic                    axm_awvalid,
    input  logic                    axm_awready,
    output logic [ADDR_WIDTH-1:0]   axm_awaddr,
    output logic [2:0]              axm_awprot,
    // AXI4-lite write data
    output logic                    axm_wvalid,
    input  logic                    axm_wready,
    output logic [31:0]             axm_wdata,
    output logic [3:0]              axm_wstrb,
    // AXI4-lite write response
    input  logic                    axm_bvalid,
    input  logic [1:0]              axm_bresp,
    output logic                    axm_bready,
    // AXI4-lite read address
    output logic                    axm_arvalid,
    input  logic                    axm_arready,
    output logic [ADDR_WIDTH-1:0]   axm_araddr,
    output logic [2:0]              axm_arprot,
    // AXI4-lite read data
    input  logic                    axm_rvalid,
    input  logic [1:0]              axm_rresp,
    output logic                    axm_rready,
    input  logic [31:0]             axm_rdata
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        WB   = 3'd2,
        RA   = 3'd3,
        RD   = 3'd4,
        RESP = 3'd5
    } state_e;

    localparam logic [ERRCNT_WIDTH-1:0] ERRCNT_MAX = '1;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic                    instr_q, instr_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    mem_ready_q, mem_ready_d;
    logic                    bus_err_q, bus_err_d;
    logic [31:0]             mem_rdata_q, mem_rdata_d;
    logic [ERRCNT_WIDTH-1:0] err_count_q, err_count_d;

    logic                    aw_ok;
    logic                    w_ok;

    // A channel counts as done once its valid has dropped or is handshaking now
    assign aw_ok = awvalid_q ? axm_awready : 1'b1;
    assign w_ok  = wvalid_q  ? axm_wready  : 1'b1;

    // Next-state, transaction latching and registered-output computation
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        instr_d     = instr_q;
        awvalid_d   = awvalid_q & ~axm_awready;
        wvalid_d    = wvalid_q & ~axm_wready;
        arvalid_d   = arvalid_q & ~axm_arready;
        bready_d    = bready_q;
        rready_d    = rready_q;
        mem_ready_d = 1'b0;
        bus_err_d   = 1'b0;
        mem_rdata_d = mem_rdata_q;
        err_count_d = err_count_q;

        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    instr_d = mem_instr;
                    if (mem_wstrb != 4'h0) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RA;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR: begin
                if (aw_ok && w_ok) begin
                    state_d  = WB;
                    bready_d = 1'b1;
                end
            end
            WB: begin
                if (axm_bvalid) begin
                    state_d     = RESP;
                    bready_d    = 1'b0;
                    mem_ready_d = 1'b1;
                    bus_err_d   = (axm_bresp != 2'b00);
                end
            end
            RA: begin
                if (axm_arready) begin
                    state_d  = RD;
                    rready_d = 1'b1;
                end
            end
            RD: begin
                if (axm_rvalid) begin
                    state_d     = RESP;
                    rready_d    = 1'b0;
                    mem_ready_d = 1'b1;
                    bus_err_d   = (axm_rresp != 2'b00);
                    mem_rdata_d = (axm_rresp != 2'b00) ? ERR_RDATA : axm_rdata;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus_err_d && (err_count_q != ERRCNT_MAX)) begin
            err_count_d = err_count_q + ERRCNT_WIDTH'(1);
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rsi_resetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            instr_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            mem_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
            mem_rdata_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            instr_q     <= instr_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            mem_ready_q <= mem_ready_d;
            bus_err_q   <= bus_err_d;
            mem_rdata_q <= mem_rdata_d;
            err_count_q <= err_count_d;
        end
    end

    assign mem_ready   = mem_ready_q;
    assign mem_rdata   = mem_rdata_q;
    assign bus_err     = bus_err_q;
    assign err_count   = err_count_q;

    assign axm_awvalid = awvalid_q;
    assign axm_awaddr  = addr_q;
    assign axm_awprot  = 3'b000;
    assign axm_wvalid  = wvalid_q;
    assign axm_wdata   = wdata_q;
    assign axm_wstrb   = wstrb_q;
    assign axm_bready  = bready_q;
    assign axm_arvalid = arvalid_q;
    assign axm_araddr  = addr_q;
    assign axm_arprot  = {(IFETCH_PROT != 0) && instr_q, 2'b00};
    assign axm_rready  = rready_q;

endmodule

// File: tb/tb_axil_mem_bridge.sv
// Bench for axil_mem_bridge: latency-programmable AXI4-lite slave, directed table,
// randomized transactions against a word-level memory model, and corner sequences.
module tb_axil_mem_bridge;

    localparam int unsigned ECW    = 2;
    localparam int unsigned EC_MAX = 3;

    logic            clk;
    logic            rsi_resetn;
    logic            mem_valid;
    logic            mem_instr;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_ready;
    logic [31:0]     mem_rdata;
    logic            bus_err;
    logic [ECW-1:0]  err_count;
    logic            axm_awvalid, axm_awready;
    logic [31:0]     axm_awaddr;
    logic [2:0]      axm_awprot;
    logic            axm_wvalid, axm_wready;
    logic [31:0]     axm_wdata;
    logic [3:0]      axm_wstrb;
    logic            axm_bvalid, axm_bready;
    logic [1:0]      axm_bresp;
    logic            axm_arvalid, axm_arready;
    logic [31:0]     axm_araddr;
    logic [2:0]      axm_arprot;
    logic            axm_rvalid, axm_rready;
    logic [1:0]      axm_rresp;
    logic [31:0]     axm_rdata;

    axil_mem_bridge #(
        .ADDR_WIDTH  (32),
        .ERR_RDATA   (32'hDEAD_BEEF),
        .ERRCNT_WIDTH(ECW),
        .IFETCH_PROT (1)
    ) dut (
        .clk        (clk),
        .rsi_resetn (rsi_resetn),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .bus_err    (bus_err),
        .err_count  (err_count),
        .axm_awvalid(axm_awvalid),
        .axm_awready(axm_awready),
        .axm_awaddr (axm_awaddr),
        .axm_awprot (axm_awprot),
        .axm_wvalid (axm_wvalid),
        .axm_wready (axm_wready),
        .axm_wdata  (axm_wdata),
        .axm_wstrb  (axm_wstrb),
        .axm_bvalid (axm_bvalid),
        .axm_bresp  (axm_bresp),
        .axm_bready (axm_bready),
        .axm_arvalid(axm_arvalid),
        .axm_arready(axm_arready),
        .axm_araddr (axm_araddr),
        .axm_arprot (axm_arprot),
        .axm_rvalid (axm_rvalid),
        .axm_rresp  (axm_rresp),
        .axm_rready (axm_rready),
        .axm_rdata  (axm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- slave with programmable wait states ----------------
    int unsigned aw_lat, w_lat, b_lat, ar_lat, r_lat;
    int unsigned aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int unsigned aw_hs_tot, ar_hs_tot, aw_hi_tot, w_hi_tot, ar_hi_tot, overlap_tot;
    logic        have_aw, have_w, ar_pend;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;
    logic [2:0]  cap_awprot, cap_arprot;
    logic [31:0] smem [256];
    logic [31:0] wmerge;

    assign axm_awready = axm_awvalid && !have_aw && (aw_cnt >= aw_lat);
    assign axm_wready  = axm_wvalid  && !have_w  && (w_cnt >= w_lat);
    assign axm_arready = axm_arvalid && !ar_pend && (ar_cnt >= ar_lat);
    assign axm_bvalid  = have_aw && have_w && (b_cnt >= b_lat);
    assign axm_rvalid  = ar_pend && (r_cnt >= r_lat);
    assign axm_bresp   = (cap_awaddr[31:28] == 4'hF) ? 2'b10 : 2'b00;
    assign axm_rresp   = (cap_araddr[31:28] == 4'hF) ? 2'b10 : 2'b00;
    assign axm_rdata   = (cap_araddr[31:28] == 4'hF) ? 32'h0BAD_F00D : smem[cap_araddr[9:2]];

    always_comb begin
        wmerge = smem[cap_awaddr[9:2]];
        for (int b = 0; b < 4; b++) begin
            if (cap_wstrb[b]) wmerge[8*b +: 8] = cap_wdata[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (!rsi_resetn) begin
            have_aw <= 1'b0; have_w <= 1'b0; ar_pend <= 1'b0;
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            for (int i = 0; i < 256; i++) smem[i] <= '0;
        end else begin
            aw_cnt <= (axm_awvalid && !axm_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (axm_wvalid && !axm_wready) ? w_cnt + 1 : 0;
            ar_cnt <= (axm_arvalid && !axm_arready) ? ar_cnt + 1 : 0;
            if (axm_awvalid && axm_awready) begin
                have_aw <= 1'b1; cap_awaddr <= axm_awaddr; cap_awprot <= axm_awprot;
                aw_hs_tot <= aw_hs_tot + 1;
            end
            if (axm_wvalid && axm_wready) begin
                have_w <= 1'b1; cap_wdata <= axm_wdata; cap_wstrb <= axm_wstrb;
            end
            if (axm_bvalid && axm_bready) begin
                have_aw <= 1'b0; have_w <= 1'b0; b_cnt <= 0;
                if (cap_awaddr[31:28] != 4'hF) smem[cap_awaddr[9:2]] <= wmerge;
            end else if (have_aw && have_w) begin
                b_cnt <= b_cnt + 1;
            end
            if (axm_arvalid && axm_arready) begin
                ar_pend <= 1'b1; cap_araddr <= axm_araddr; cap_arprot <= axm_arprot;
                ar_hs_tot <= ar_hs_tot + 1;
            end
            if (axm_rvalid && axm_rready) begin
                ar_pend <= 1'b0; r_cnt <= 0;
            end else if (ar_pend) begin
                r_cnt <= r_cnt + 1;
            end
        end
    end

    // Valid-high cycle counts and AW/W vs AR overlap tracking
    initial begin
        aw_hs_tot = 0; ar_hs_tot = 0; aw_hi_tot = 0; w_hi_tot = 0; ar_hi_tot = 0; overlap_tot = 0;
    end
    always @(posedge clk) begin
        if (axm_awvalid) aw_hi_tot <= aw_hi_tot + 1;
        if (axm_wvalid)  w_hi_tot  <= w_hi_tot + 1;
        if (axm_arvalid) ar_hi_tot <= ar_hi_tot + 1;
        if ((axm_awvalid || axm_wvalid || axm_bready) && (axm_arvalid || axm_rready))
            overlap_tot <= overlap_tot + 1;
    end

    // ---------------- checking infrastructure ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
        int unsigned l_aw, l_w, l_b, l_ar, l_r;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int unsigned exp_lat;
    } vec_t;

    int unsigned checks;
    int unsigned errors;
    int unsigned exp_ec;
    logic [31:0] ref_mem [int unsigned];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:28] == 4'hF) return 32'hDEAD_BEEF;
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return 32'h0;
    endfunction

    // Issue one request (DUT idle, called #1 after a posedge) and check everything about it
    task automatic run_txn(input string tag, input vec_t v);
        int unsigned awh0, arh0, awhi0, whi0, arhi0, cyc;
        bit          got, is_wr;
        logic [31:0] rd, old;
        logic        er;
        is_wr  = (v.wstrb != 4'h0);
        aw_lat = v.l_aw; w_lat = v.l_w; b_lat = v.l_b; ar_lat = v.l_ar; r_lat = v.l_r;
        awh0 = aw_hs_tot; arh0 = ar_hs_tot; awhi0 = aw_hi_tot; whi0 = w_hi_tot; arhi0 = ar_hi_tot;
        mem_valid = 1'b1; mem_addr = v.addr; mem_wdata = v.wdata;
        mem_wstrb = v.wstrb; mem_instr = v.instr;
        @(posedge clk); #1;
        // Scramble the request inputs: the latched transaction must be unaffected
        mem_valid = 1'b0; mem_addr = $urandom; mem_wdata = $urandom;
        mem_wstrb = 4'($urandom); mem_instr = 1'($urandom);
        cyc = 0; got = 1'b0;
        while (!got && cyc < 64) begin
            cyc++;
            if (mem_ready) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk($sformatf("%s_done", tag), 32'(got), 32'd1);
        if (!got) return;
        rd = mem_rdata; er = bus_err;
        chk($sformatf("%s_latency", tag), 32'(cyc), 32'(v.exp_lat));
        chk($sformatf("%s_bus_err", tag), 32'(er), 32'(v.exp_err));
        if (!is_wr) chk($sformatf("%s_rdata", tag), rd, v.exp_rdata);
        @(posedge clk); #1;
        chk($sformatf("%s_single_pulse", tag), {30'd0, mem_ready, bus_err}, 32'd0);
        if (v.exp_err && exp_ec < EC_MAX) exp_ec++;
        chk($sformatf("%s_err_count", tag), 32'(err_count), 32'(exp_ec));
        if (is_wr) begin
            chk($sformatf("%s_awaddr", tag), cap_awaddr, v.addr);
            chk($sformatf("%s_wdata", tag), cap_wdata, v.wdata);
            chk($sformatf("%s_wstrb", tag), 32'(cap_wstrb), 32'(v.wstrb));
            chk($sformatf("%s_awprot", tag), 32'(cap_awprot), 32'd0);
            chk($sformatf("%s_aw_count", tag), aw_hs_tot - awh0, 32'd1);
            chk($sformatf("%s_ar_count", tag), ar_hs_tot - arh0, 32'd0);
            chk($sformatf("%s_awvalid_cycles", tag), aw_hi_tot - awhi0, v.l_aw + 1);
            chk($sformatf("%s_wvalid_cycles", tag), w_hi_tot - whi0, v.l_w + 1);
            if (v.addr[31:28] != 4'hF) begin
                old = model_read(v.addr);
                for (int b = 0; b < 4; b++) if (v.wstrb[b]) old[8*b +: 8] = v.wdata[8*b +: 8];
                ref_mem[int'(v.addr)] = old;
            end
        end else begin
            chk($sformatf("%s_araddr", tag), cap_araddr, v.addr);
            chk($sformatf("%s_arprot", tag), 32'(cap_arprot), 32'({v.instr, 2'b00}));
            chk($sformatf("%s_ar_count", tag), ar_hs_tot - arh0, 32'd1);
            chk($sformatf("%s_aw_count", tag), aw_hs_tot - awh0, 32'd0);
            chk($sformatf("%s_arvalid_cycles", tag), ar_hi_tot - arhi0, v.l_ar + 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        vec_t        tbl [10];
        vec_t        v;
        int unsigned cyc, pulses, arh0, last;
        int unsigned pulse_at [3];
        logic [31:0] exp_b2b;

        checks = 0; errors = 0; exp_ec = 0;
        aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 0;
        rsi_resetn = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;

        //          addr           wdata          wstrb  ins aw w  b  ar r  exp_rdata      err  lat
        tbl[0] = '{32'h0000_0100, 32'h1234_5678, 4'hF, 0, 0, 0, 0, 0, 0, 32'h0,          0,   3};
        tbl[1] = '{32'h0000_0104, 32'hCAFE_F00D, 4'hF, 0, 4, 0, 0, 0, 0, 32'h0,          0,   7};
        tbl[2] = '{32'h0000_0000, 32'h0000_0013, 4'hF, 0, 0, 1, 2, 0, 0, 32'h0,          0,   6};
        tbl[3] = '{32'h0000_0000, 32'h0,         4'h0, 1, 0, 0, 0, 0, 0, 32'h0000_0013,  0,   3};
        tbl[4] = '{32'h0000_0100, 32'h0,         4'h0, 0, 0, 0, 0, 1, 2, 32'h1234_5678,  0,   6};
        tbl[5] = '{32'hF000_0000, 32'h0,         4'h0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF,  1,   3};
        tbl[6] = '{32'hF000_0010, 32'h5555_AAAA, 4'hF, 0, 0, 0, 1, 0, 0, 32'h0,          1,   4};
        tbl[7] = '{32'h0000_0100, 32'hAABB_CCDD, 4'h5, 0, 1, 3, 0, 0, 0, 32'h0,          0,   6};
        tbl[8] = '{32'h0000_0100, 32'h0,         4'h0, 0, 0, 0, 0, 2, 1, 32'h12BB_56DD,  0,   6};
        tbl[9] = '{32'h0000_0104, 32'h0,         4'h0, 1, 0, 0, 0, 0, 0, 32'hCAFE_F00D,  0,   3};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valids_readies", {25'd0, axm_awvalid, axm_wvalid, axm_arvalid, axm_bready,
                                   axm_rready, mem_ready, bus_err}, 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        rsi_resetn = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 10; i++) run_txn($sformatf("tbl%0d", i), tbl[i]);

        // Three more error responses: five in total with a 2-bit counter saturate at 3
        for (int i = 0; i < 3; i++) begin
            v = '{32'hF000_0040, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 1, 3};
            run_txn($sformatf("sat%0d", i), v);
        end
        chk("err_count_saturated", 32'(err_count), 32'd3);

        // Back-to-back reads with mem_valid held through RESP
        aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 0;
        exp_b2b = model_read(32'h100);
        arh0 = ar_hs_tot; pulses = 0; cyc = 0;
        mem_valid = 1'b1; mem_addr = 32'h100; mem_wstrb = 4'h0; mem_instr = 1'b0;
        while (pulses < 3 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_ready) begin
                pulse_at[pulses] = cyc;
                chk($sformatf("b2b_rdata%0d", pulses), mem_rdata, exp_b2b);
                pulses++;
                if (pulses == 3) mem_valid = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_pulses", pulses, 32'd3);
        chk("b2b_ar_count", ar_hs_tot - arh0, 32'd3);
        if (pulses == 3) begin
            chk("b2b_first_latency", pulse_at[0], 32'd3);
            chk("b2b_gap1", pulse_at[1] - pulse_at[0], 32'd4);
            chk("b2b_gap2", pulse_at[2] - pulse_at[1], 32'd4);
        end

        // Randomized traffic against the memory model
        for (int i = 0; i < 40; i++) begin
            logic is_err, is_wr;
            is_err = ($urandom_range(0, 7) == 0);
            is_wr  = 1'($urandom_range(0, 1));
            v.addr  = (is_err ? 32'hF000_0000 : 32'h0) | 32'($urandom_range(0, 15) << 2);
            v.wdata = $urandom;
            v.wstrb = is_wr ? 4'($urandom_range(1, 15)) : 4'h0;
            v.instr = 1'($urandom);
            v.l_aw = $urandom_range(0, 3); v.l_w = $urandom_range(0, 3);
            v.l_b  = $urandom_range(0, 3); v.l_ar = $urandom_range(0, 3);
            v.l_r  = $urandom_range(0, 3);
            v.exp_err   = is_err;
            v.exp_rdata = model_read(v.addr);
            v.exp_lat   = is_wr ? 3 + ((v.l_aw > v.l_w) ? v.l_aw : v.l_w) + v.l_b
                                : 3 + v.l_ar + v.l_r;
            run_txn($sformatf("rnd%0d", i), v);
        end

        // Reset while waiting in the read-data phase
        aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 8;
        mem_valid = 1'b1; mem_addr = 32'h100; mem_wstrb = 4'h0; mem_instr = 1'b0;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        cyc = 0;
        while (!axm_rready && cyc < 20) begin @(posedge clk); #1; cyc++; end
        chk("rstrd_reached_rd", 32'(axm_rready), 32'd1);
        rsi_resetn = 1'b0;
        @(posedge clk); #1;
        chk("rstrd_rready", 32'(axm_rready), 32'd0);
        chk("rstrd_others", {26'd0, axm_awvalid, axm_wvalid, axm_arvalid, axm_bready,
                             mem_ready, bus_err}, 32'd0);
        chk("rstrd_err_count", 32'(err_count), 32'd0);
        chk("rstrd_mem_rdata", mem_rdata, 32'd0);
        rsi_resetn = 1'b1;
        r_lat = 0;
        last = 0;
        repeat (12) begin @(posedge clk); #1; if (mem_ready) last++; end
        chk("rstrd_no_ready", last, 32'd0);
        exp_ec = 0;
        ref_mem.delete();

        // Bridge must be back in IDLE and fully functional
        v = '{32'h0000_0020, 32'h0BEE_F00D, 4'hF, 0, 0, 0, 0, 0, 0, 32'h0, 0, 3};
        run_txn("post_rst_wr", v);
        v = '{32'h0000_0020, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 32'h0BEE_F00D, 0, 3};
        run_txn("post_rst_rd", v);

        chk("no_aw_ar_overlap", overlap_tot, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_mem_bridge.md
AXIL_MEM_BRIDGE -- requirements
Module: axil_mem_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32: width of mem_addr, axm_awaddr and axm_araddr.
REQ-002 The block SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF: value returned on mem_rdata for a read that completes with an error response.
REQ-003 The block SHALL have parameter ERRCNT_WIDTH, default 8: width of err_count.
REQ-004 The block SHALL have parameter IFETCH_PROT, default 1: when 1, axm_arprot[2] = mem_instr; when 0, axm_arprot = 3'b000.
REQ-005 Ports SHALL be:
- clk  in  1  the single clock.
- rsi_resetn  in  1  reset; synchronous, active-low.
- mem_valid  in  1  CPU request.
- mem_instr  in  1  request is an instruction fetch.
- mem_addr  in  ADDR_WIDTH  byte address.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte enables; 0 means read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data, valid while mem_ready=1.
- bus_err  out  1  one-cycle pulse coincident with mem_ready on an error response.
- err_count  out  ERRCNT_WIDTH  saturating count of error responses.
- axm_awvalid/awready/awaddr[ADDR_WIDTH]/awprot[3], axm_wvalid/wready/wdata[32]/wstrb[4], axm_bvalid/bresp[2]/bready, axm_arvalid/arready/araddr[ADDR_WIDTH]/arprot[3], axm_rvalid/rresp[2]/rready/rdata[32]: AXI4-lite master channels.
REQ-006 The block SHALL use one clock, clk; reset rsi_resetn SHALL be synchronous and active-low.

Function
REQ-007 The FSM SHALL have exactly these states: IDLE, WR, WB, RA, RD, RESP.
REQ-008 In IDLE, when mem_valid=1, the block SHALL latch addr, wdata, wstrb and instr, then go to WR if wstrb!=0, else to RA.
REQ-009 On entry to WR, axm_awvalid and axm_wvalid SHALL both go to 1.
REQ-010 In WR, each of axm_awvalid and axm_wvalid SHALL drop independently on the cycle after its own handshake (valid&&ready).
REQ-011 The block SHALL go from WR to WB once both the AW and W handshakes have occurred, whether in the same cycle or in different cycles.
REQ-012 In WB, axm_bready SHALL be 1; on bvalid the block SHALL capture bresp and go to RESP.
REQ-013 In RA, axm_arvalid SHALL be 1 until arready, then the block SHALL go to RD.
REQ-014 In RD, axm_rready SHALL be 1; on rvalid the block SHALL capture rdata and rresp and go to RESP.
REQ-015 In RESP, for exactly one cycle:
- mem_ready SHALL be 1;
- mem_rdata SHALL be the captured rdata, or ERR_RDATA if rresp!=0 (value unspecified for writes);
- bus_err SHALL be 1 iff the captured resp!=0.
The block SHALL then go to IDLE.
REQ-016 The block SHALL not accept a new request in the RESP cycle; the earliest new acceptance is the first IDLE cycle after RESP.
REQ-017 Once the block has left IDLE, a change on mem_valid or the mem_* inputs SHALL have no effect; the latched transaction always completes.
REQ-018 All valid signals SHALL stay asserted until their handshake; no timeout and no abort.
REQ-019 axm_awaddr and axm_araddr SHALL be the latched address, unmodified. axm_wdata and axm_wstrb SHALL be the latched values. axm_awprot SHALL be 3'b000. axm_arprot SHALL be {IFETCH_PROT & instr, 2'b00}.
REQ-020 err_count SHALL increment by 1 on each bus_err pulse and saturate at all-ones.
REQ-021 With a zero-wait slave (readies=1, response returned the cycle after the address handshake), mem_ready SHALL assert 3 cycles after the IDLE acceptance cycle, for both reads and writes.
REQ-022 Only one transaction SHALL be outstanding at any time; AW/W and AR SHALL never be active together.

Reset
REQ-023 While rsi_resetn=0 at a clk edge, the block SHALL go to state IDLE and SHALL set to 0: all axm_*valid, axm_bready, axm_rready, mem_ready, bus_err, err_count and mem_rdata.
REQ-024 Reset asserted mid-transaction SHALL abandon that transaction: valids are low in the cycle after the reset edge, and no mem_ready is issued for it.

Verification
REQ-025 Zero-wait write, addr 0x100, wdata 0x12345678, wstrb 4'hF -> awaddr=0x100, wdata=0x12345678, one mem_ready pulse at acceptance+3, bus_err=0.
REQ-026 Write with awready delayed 4 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid is held for 5 cycles, B is only accepted after both handshakes, exactly one mem_ready pulse.
REQ-027 Instruction-fetch read, addr 0x0, rdata 0x00000013, IFETCH_PROT=1 -> arprot=3'b100, mem_rdata=0x00000013 during mem_ready.
REQ-028 Read with rresp=2'b10 -> mem_rdata=0xDEADBEEF, bus_err=1 for one cycle, err_count 0->1; with ERRCNT_WIDTH=2, five error responses leave err_count at 3.
REQ-029 Back-to-back reads with mem_valid held high through RESP -> exactly one AR per request, no acceptance in the RESP cycle.
REQ-030 Reset asserted while in RD -> rready=0 next cycle, state IDLE, no mem_ready pulse, err_count=0.
